piece_cell_gen: RTL and testbench
=================================

Name: piece_cell_gen

Overview:
Parametrised successor of the spawn-cell generator. On request it emits the four board cells of a tetromino one per cycle, in spawn mode (next piece from an internal preview queue, or a held piece) or probe mode (caller-supplied piece, anchor and rotation, used by the rotate/move legality checkers). Sits between the game FSM and the board-collision/write logic. It owns the random source and a preview queue of configurable depth.

Parameters:
COORD_W, 5, width of row/column coordinates
BOARD_ROWS, 20, rows; row index >= BOARD_ROWS is out of bounds
BOARD_COLS, 10, columns; column index >= BOARD_COLS is out of bounds
SPAWN_ROW, 0, anchor row used in spawn mode
SPAWN_COL, 3, anchor column used in spawn mode
PREVIEW_DEPTH, 3, preview queue entries (1..7)
LFSR_SEED, 16'hACE1, non-zero reset value of the random LFSR

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
req  in  1  start request; accepted only when ready=1
mode  in  1  0 = spawn, 1 = probe
hold_piece_type  in  3  spawn: non-`NULL_PIECE means use this piece, queue untouched
piece_in  in  3  probe: piece type
anchor_i, anchor_j  in  COORD_W each  probe: bounding-box top-left
rot_in  in  2  probe: clockwise quarter turns 0..3
ready  out  1  idle and queue full
cell_valid  out  1  cell_i/cell_j valid this cycle
cell_idx  out  2  index 0..3 of current cell
cell_i, cell_j  out  COORD_W each  cell coordinates
piece_type  out  3  piece being emitted, held from acceptance to done
oob  out  1  valid with done: any cell out of bounds
done  out  1  one-cycle pulse after last cell
next_tetris  out  3  queue head (preview slot 0)

Behaviour:
- Reset (async): FSM FILL, queue empty, LFSR=LFSR_SEED, all outputs 0 except piece_type/next_tetris = `NULL_PIECE.
- Piece table order Q,S,Z,T,L,J,I with the codebase header codes. Rot-0 offsets (row,col) from anchor: Q (0,1)(0,2)(1,1)(1,2); S (0,1)(0,2)(1,0)(1,1); Z (0,0)(0,1)(1,1)(1,2); T (0,1)(1,0)(1,1)(1,2); L (0,2)(1,0)(1,1)(1,2); J (0,0)(1,0)(1,1)(1,2); I (1,0)(1,1)(1,2)(1,3). Cells emitted in this order.
- Rotation: each clockwise turn maps (r,c) -> (c, N-1-r), N=4 for I, N=3 for S,Z,T,L,J; Q ignores rotation. Spawn mode always rot 0.
- Coordinates computed at COORD_W+1 bits; oob set if any sum >= BOARD_ROWS (row) or >= BOARD_COLS (col); cell_i/cell_j output truncated to COORD_W.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, steps every cycle. Sample v = low 3 bits; v in 1..7 selects table entry v-1; v=0 rejected (no push that cycle).
- FSM: FILL -> IDLE when queue holds PREVIEW_DEPTH entries; one valid sample pushed per cycle while not full. IDLE: ready=1; req accepted -> EMIT. EMIT: 4 cycles, cell_valid=1, cell_idx 0,1,2,3. Then DONE: done=1, oob valid, one cycle -> IDLE if queue full else FILL.
- Acceptance latency: first cell_valid the cycle after req is sampled; done 5 cycles after acceptance.
- Spawn with hold_piece_type = `NULL_PIECE: piece_type = head, head popped at acceptance, refill begins next cycle (runs in parallel with EMIT). Spawn with hold: piece_type = hold_piece_type, no pop. Probe: no pop.
- Inputs sampled only at acceptance; later changes ignored. req while ready=0 ignored (not queued).
- oob cells are still emitted; caller decides.
- Reset mid-EMIT aborts immediately, no done.

Test Plan:
- Reset, LFSR_SEED default -> ready rises after >= PREVIEW_DEPTH cycles; next_tetris != `NULL_PIECE; no cell_valid before req.
- Spawn, no hold, head = T -> cells (0,4)(1,3)(1,4)(1,5), cell_idx 0..3, done 5 cycles after req, oob=0; next_tetris shifts to old slot 1.
- Spawn with hold = I -> cells (1,3)(1,4)(1,5)(1,6); next_tetris unchanged.
- Probe I, anchor (5,2), rot 1 -> cells (5,4)(6,4)(7,4)(8,4), oob=0; probe L, anchor (0,8), rot 0 -> cell (0,10) emitted, oob=1.
- Probe Q rot 3 equals rot 0; req pulsed during EMIT -> ignored, single done.
- Assert reset during EMIT cell 2 -> cell_valid=0 immediately, no done, FILL restarts from LFSR_SEED.

Source files
------------

// File: rtl/piece_cell_gen.sv
// Tetromino cell generator: owns the random piece source and preview queue, and emits
// the four board cells of a spawned or probed piece one per cycle, flagging out-of-bounds.
module piece_cell_gen #(
  parameter int          COORD_W       = 5,
  parameter int          BOARD_ROWS    = 20,
  parameter int          BOARD_COLS    = 10,
  parameter int          SPAWN_ROW     = 0,
  parameter int          SPAWN_COL     = 3,
  parameter int          PREVIEW_DEPTH = 3,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req,
  input  logic               mode,
  input  logic [2:0]         hold_piece_type,
  input  logic [2:0]         piece_in,
  input  logic [COORD_W-1:0] anchor_i,
  input  logic [COORD_W-1:0] anchor_j,
  input  logic [1:0]         rot_in,
  output logic               ready,
  output logic               cell_valid,
  output logic [1:0]         cell_idx,
  output logic [COORD_W-1:0] cell_i,
  output logic [COORD_W-1:0] cell_j,
  output logic [2:0]         piece_type,
  output logic               oob,
  output logic               done,
  output logic [2:0]         next_tetris,
  output logic [1:0]         dbg_state
);

  localparam logic [2:0] NULL_PIECE = 3'd0;
  localparam logic [2:0] PC_Q = 3'd1, PC_S = 3'd2, PC_Z = 3'd3, PC_T = 3'd4;
  localparam logic [2:0] PC_L = 3'd5, PC_J = 3'd6, PC_I = 3'd7;

  localparam int                 CNT_W  = $clog2(PREVIEW_DEPTH + 1);
  localparam logic [CNT_W-1:0]   FULL   = CNT_W'(PREVIEW_DEPTH);
  localparam logic [COORD_W:0]   ROWS_L = (COORD_W+1)'(BOARD_ROWS);
  localparam logic [COORD_W:0]   COLS_L = (COORD_W+1)'(BOARD_COLS);

  // Handshake: a request is taken on any rising edge where req=1 and ready=1; req while
  // ready=0 is dropped, and all request inputs are captured only on that accepting edge.
  typedef enum logic [1:0] {ST_FILL, ST_IDLE, ST_EMIT, ST_DONE} state_t;

  state_t               state_q;
  logic [15:0]          lfsr_q, lfsr_d;
  logic [2:0]           queue_q [PREVIEW_DEPTH];
  logic [CNT_W-1:0]     count_q;
  logic [2:0]           pt_q;
  logic [1:0]           rot_q, idx_q;
  logic [COORD_W-1:0]   ai_q, aj_q, ci_q, cj_q;
  logic                 cell_valid_q, done_q, oob_q, oob_acc_q;

  logic [2:0]           head, sample, src_pc;
  logic                 push, accept, pop, cell_oob;
  logic [1:0]           src_rot, src_k;
  logic [COORD_W-1:0]   src_ai, src_aj;
  logic [3:0]           off;
  logic [COORD_W:0]     row_sum, col_sum;

  // Each piece packs four {row,col} nibbles, cell 0 in the low nibble.
  function automatic logic [3:0] cell_offset(input logic [2:0] pc, input logic [1:0] rot,
                                             input logic [1:0] k);
    logic [15:0] tbl;
    logic [1:0]  r, c, r_nxt, n_m1;
    case (pc)
      PC_Q:    tbl = 16'h6521;
      PC_S:    tbl = 16'h5421;
      PC_Z:    tbl = 16'h6510;
      PC_T:    tbl = 16'h6541;
      PC_L:    tbl = 16'h6542;
      PC_J:    tbl = 16'h6540;
      PC_I:    tbl = 16'h7654;
      default: tbl = 16'h0000;
    endcase
    {r, c} = tbl[{k, 2'b00} +: 4];
    r_nxt  = 2'd0;
    n_m1   = (pc == PC_I) ? 2'd3 : 2'd2;
    if (pc != PC_Q) begin
      for (int t = 0; t < 3; t++) begin
        if (2'(t) < rot) begin
          r_nxt = c;
          c     = n_m1 - r;
          r     = r_nxt;
        end
      end
    end
    return {r, c};
  endfunction

  assign head   = (count_q != '0) ? queue_q[0] : NULL_PIECE;
  assign sample = lfsr_q[2:0];
  assign push   = (count_q < FULL) && (sample != 3'd0);
  assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign ready  = (state_q == ST_IDLE) && (count_q == FULL);
  assign accept = ready && req;
  assign pop    = accept && !mode && (hold_piece_type == NULL_PIECE);

  // In IDLE the cell path looks at the live request so cell 0 can register on acceptance.
  always_comb begin
    if (state_q == ST_IDLE) begin
      src_k = 2'd0;
      if (mode) begin
        src_pc  = piece_in;
        src_rot = rot_in;
        src_ai  = anchor_i;
        src_aj  = anchor_j;
      end else begin
        src_pc  = (hold_piece_type != NULL_PIECE) ? hold_piece_type : head;
        src_rot = 2'd0;
        src_ai  = COORD_W'(SPAWN_ROW);
        src_aj  = COORD_W'(SPAWN_COL);
      end
    end else begin
      src_k   = idx_q + 2'd1;
      src_pc  = pt_q;
      src_rot = rot_q;
      src_ai  = ai_q;
      src_aj  = aj_q;
    end
    off      = cell_offset(src_pc, src_rot, src_k);
    row_sum  = {1'b0, src_ai} + {{(COORD_W-1){1'b0}}, off[3:2]};
    col_sum  = {1'b0, src_aj} + {{(COORD_W-1){1'b0}}, off[1:0]};
    cell_oob = (row_sum >= ROWS_L) || (col_sum >= COLS_L);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_FILL;
      lfsr_q       <= LFSR_SEED;
      count_q      <= '0;
      for (int i = 0; i < PREVIEW_DEPTH; i++) queue_q[i] <= NULL_PIECE;
      pt_q         <= NULL_PIECE;
      rot_q        <= 2'd0;
      idx_q        <= 2'd0;
      ai_q         <= '0;
      aj_q         <= '0;
      ci_q         <= '0;
      cj_q         <= '0;
      cell_valid_q <= 1'b0;
      done_q       <= 1'b0;
      oob_q        <= 1'b0;
      oob_acc_q    <= 1'b0;
    end else begin
      lfsr_q <= lfsr_d;
      done_q <= 1'b0;
      oob_q  <= 1'b0;
      // Pop only happens with the queue full, so it never coincides with a push.
      if (pop) begin
        for (int i = 0; i < PREVIEW_DEPTH - 1; i++) queue_q[i] <= queue_q[i+1];
        queue_q[PREVIEW_DEPTH-1] <= NULL_PIECE;
        count_q <= count_q - 1'b1;
      end else if (push) begin
        for (int i = 0; i < PREVIEW_DEPTH; i++)
          if (count_q == CNT_W'(i)) queue_q[i] <= sample;
        count_q <= count_q + 1'b1;
      end
      case (state_q)
        ST_FILL: if (count_q == FULL) state_q <= ST_IDLE;
        ST_IDLE: begin
          if (accept) begin
            state_q      <= ST_EMIT;
            pt_q         <= src_pc;
            rot_q        <= src_rot;
            ai_q         <= src_ai;
            aj_q         <= src_aj;
            idx_q        <= 2'd0;
            ci_q         <= row_sum[COORD_W-1:0];
            cj_q         <= col_sum[COORD_W-1:0];
            cell_valid_q <= 1'b1;
            oob_acc_q    <= cell_oob;
          end
        end
        ST_EMIT: begin
          if (idx_q == 2'd3) begin
            state_q      <= ST_DONE;
            cell_valid_q <= 1'b0;
            done_q       <= 1'b1;
            oob_q        <= oob_acc_q;
          end else begin
            idx_q        <= src_k;
            ci_q         <= row_sum[COORD_W-1:0];
            cj_q         <= col_sum[COORD_W-1:0];
            oob_acc_q    <= oob_acc_q | cell_oob;
          end
        end
        default: state_q <= (count_q == FULL) ? ST_IDLE : ST_FILL;
      endcase
    end
  end

  assign cell_valid  = cell_valid_q;
  assign cell_idx    = idx_q;
  assign cell_i      = ci_q;
  assign cell_j      = cj_q;
  assign piece_type  = pt_q;
  assign oob         = oob_q;
  assign done        = done_q;
  assign next_tetris = head;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_piece_cell_gen.sv
// Bench for piece_cell_gen: randomized spawn/probe requests checked against a queue-based
// piece model and a shape/rotation table computed directly from the piece rules.
module tb_piece_cell_gen;

  localparam int CW = 5;
  localparam int DEPTH = 3;
  localparam logic [2:0] NULLP = 3'd0, PQ = 3'd1, PT = 3'd4, PL = 3'd5, PI = 3'd7;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req = 1'b0, mode = 1'b0;
  logic [2:0] hold_piece_type = 3'd0, piece_in = 3'd0;
  logic [CW-1:0] anchor_i = '0, anchor_j = '0;
  logic [1:0] rot_in = 2'd0;
  logic ready, cell_valid, oob, done;
  logic [1:0] cell_idx, dbg_state;
  logic [CW-1:0] cell_i, cell_j;
  logic [2:0] piece_type, next_tetris;

  int checks = 0;
  int errors = 0;
  int first_fill = 0;

  piece_cell_gen dut (
    .clk(clk), .reset(reset), .req(req), .mode(mode), .hold_piece_type(hold_piece_type),
    .piece_in(piece_in), .anchor_i(anchor_i), .anchor_j(anchor_j), .rot_in(rot_in),
    .ready(ready), .cell_valid(cell_valid), .cell_idx(cell_idx), .cell_i(cell_i),
    .cell_j(cell_j), .piece_type(piece_type), .oob(oob), .done(done),
    .next_tetris(next_tetris), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Rot-0 shapes, rows Q,S,Z,T,L,J,I.
  int tab_r [7][4] = '{'{0,0,1,1}, '{0,0,1,1}, '{0,0,1,1}, '{0,1,1,1},
                       '{0,1,1,1}, '{0,1,1,1}, '{1,1,1,1}};
  int tab_c [7][4] = '{'{1,2,1,2}, '{1,2,0,1}, '{0,1,1,2}, '{1,0,1,2},
                       '{2,0,1,2}, '{0,0,1,2}, '{0,1,2,3}};

  // Reference model: random source, preview queue and busy/idle phase.
  logic [15:0] m_lfsr = 16'hACE1;
  logic [2:0]  pq[$];
  int          m_phase = 0;
  int          m_cnt = 0;
  int          m_pre;
  bit          m_pop;
  logic        m_fb;

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      m_lfsr = 16'hACE1; pq.delete(); m_phase = 0; m_cnt = 0;
    end else begin
      m_pre = pq.size();
      m_pop = 1'b0;
      if (m_phase == 0) begin
        if (m_pre == DEPTH) m_phase = 1;
      end else if (m_phase == 1) begin
        if (req) begin
          m_phase = 2; m_cnt = 5;
          m_pop = (mode == 1'b0) && (hold_piece_type == NULLP);
        end
      end else begin
        m_cnt--;
        if (m_cnt == 0) m_phase = (m_pre == DEPTH) ? 1 : 0;
      end
      if (m_pre < DEPTH && m_lfsr[2:0] != 3'd0) pq.push_back(m_lfsr[2:0]);
      if (m_pop) void'(pq.pop_front());
      m_fb = m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10];
      m_lfsr = {m_lfsr[14:0], m_fb};
    end
  end

  int e_i[4], e_j[4];
  bit e_oob;

  task automatic expect_piece(input logic [2:0] pc, input int rot, input int ai, input int aj);
    int r, c, n, rr, cc, eff;
    e_oob = 1'b0;
    for (int k = 0; k < 4; k++) begin
      r = tab_r[pc-1][k]; c = tab_c[pc-1][k];
      n = (pc == PI) ? 4 : 3;
      eff = (pc == PQ) ? 0 : rot;
      case (eff)
        0: begin rr = r;         cc = c;         end
        1: begin rr = c;         cc = n - 1 - r; end
        2: begin rr = n - 1 - r; cc = n - 1 - c; end
        default: begin rr = n - 1 - c; cc = r;   end
      endcase
      if (ai + rr >= 20 || aj + cc >= 10) e_oob = 1'b1;
      e_i[k] = (ai + rr) % 32;
      e_j[k] = (aj + cc) % 32;
    end
  endtask

  logic          o_v[6], o_done[6], o_oob[6];
  logic [1:0]    o_idx[6];
  logic [CW-1:0] o_i[6], o_j[6];
  logic [2:0]    o_pt[6], o_nt[6];

  task automatic wait_idle();
    int n = 0;
    while (m_phase != 1 && n < 200) begin @(negedge clk); n++; end
    if (m_phase != 1) begin
      checks++; errors++;
      $display("FAIL wait_idle model never idle after %0d cycles", n);
    end
  endtask

  // Drives one request; afterwards scrambles the request inputs, which must be ignored.
  task automatic send_req(input logic m, input logic [2:0] hold, input logic [2:0] pc,
                          input int ai, input int aj, input int rot);
    mode = m; hold_piece_type = hold; piece_in = pc;
    anchor_i = ai[CW-1:0]; anchor_j = aj[CW-1:0]; rot_in = rot[1:0];
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    mode = 1'($urandom_range(0, 1)); hold_piece_type = 3'($urandom_range(0, 7));
    piece_in = 3'($urandom_range(1, 7)); anchor_i = CW'($urandom_range(0, 31));
    anchor_j = CW'($urandom_range(0, 31)); rot_in = 2'($urandom_range(0, 3));
  endtask

  task automatic collect();
    for (int s = 0; s < 6; s++) begin
      if (s > 0) @(negedge clk);
      o_v[s] = cell_valid; o_idx[s] = cell_idx; o_i[s] = cell_i; o_j[s] = cell_j;
      o_done[s] = done; o_oob[s] = oob; o_pt[s] = piece_type; o_nt[s] = next_tetris;
    end
  endtask

  task automatic test_reset();
    int n = 0;
    bit saw_valid = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (ready !== 1'b0 || cell_valid !== 1'b0 || done !== 1'b0 || oob !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got ready=%b valid=%b done=%b oob=%b exp all 0",
               ready, cell_valid, done, oob);
    end
    checks++;
    if (piece_type !== NULLP || next_tetris !== NULLP || cell_idx !== 2'd0) begin
      errors++;
      $display("FAIL reset_values got piece=%0d next=%0d idx=%0d exp 0 0 0",
               piece_type, next_tetris, cell_idx);
    end
    reset = 1'b0;
    while (ready !== 1'b1 && n < 100) begin
      @(negedge clk); n++;
      if (cell_valid === 1'b1) saw_valid = 1'b1;
    end
    first_fill = n;
    checks++;
    if (ready !== 1'b1 || n < DEPTH) begin
      errors++;
      $display("FAIL reset_fill got ready=%b after %0d cycles exp 1 after >= %0d", ready, n, DEPTH);
    end
    checks++;
    if (ready !== (m_phase == 1)) begin
      errors++;
      $display("FAIL reset_ready_model got %b exp %b", ready, m_phase == 1);
    end
    checks++;
    if (next_tetris === NULLP || next_tetris !== pq[0]) begin
      errors++;
      $display("FAIL reset_head got %0d exp %0d", next_tetris, pq[0]);
    end
    checks++;
    if (saw_valid) begin
      errors++;
      $display("FAIL reset_no_cells got cell_valid=1 exp 0 before any request");
    end
  endtask

  task automatic test_spawn();
    bit seen_t = 1'b0;
    logic [2:0] exp_pc, slot1;
    for (int n = 0; n < 40 && !(seen_t && n >= 6); n++) begin
      wait_idle();
      checks++;
      if (ready !== 1'b1) begin errors++; $display("FAIL spawn_ready got %b exp 1", ready); end
      exp_pc = pq[0];
      slot1 = pq[1];
      expect_piece(exp_pc, 0, 0, 3);
      send_req(1'b0, NULLP, 3'd0, 0, 0, 0);
      collect();
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (o_v[k] !== 1'b1 || o_idx[k] !== 2'(k) || o_i[k] !== CW'(e_i[k]) || o_j[k] !== CW'(e_j[k])) begin
          errors++;
          $display("FAIL spawn_cell%0d piece %0d got v=%b idx=%0d (%0d,%0d) exp v=1 idx=%0d (%0d,%0d)",
                   k, exp_pc, o_v[k], o_idx[k], o_i[k], o_j[k], k, e_i[k], e_j[k]);
        end
      end
      checks++;
      if (o_pt[0] !== exp_pc || o_pt[3] !== exp_pc) begin
        errors++; $display("FAIL spawn_piece got %0d/%0d exp %0d", o_pt[0], o_pt[3], exp_pc);
      end
      checks++;
      if (o_done[3] !== 1'b0 || o_done[4] !== 1'b1 || o_v[4] !== 1'b0 || o_done[5] !== 1'b0 || o_oob[4] !== e_oob) begin
        errors++;
        $display("FAIL spawn_done got done=%b%b%b valid4=%b oob=%b exp 010 0 %b",
                 o_done[3], o_done[4], o_done[5], o_v[4], o_oob[4], e_oob);
      end
      checks++;
      if (o_nt[0] !== slot1) begin
        errors++; $display("FAIL spawn_shift got next=%0d exp %0d", o_nt[0], slot1);
      end
      if (exp_pc == PT) seen_t = 1'b1;
    end
    checks++;
    if (!seen_t) begin errors++; $display("FAIL spawn_t got no T head exp at least one"); end
  endtask

  task automatic test_hold();
    logic [2:0] hold, head;
    for (int n = 0; n < 6; n++) begin
      hold = (n == 0) ? PI : 3'($urandom_range(1, 7));
      wait_idle();
      head = pq[0];
      expect_piece(hold, 0, 0, 3);
      send_req(1'b0, hold, 3'($urandom_range(1, 7)), 9, 9, 2);
      collect();
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (o_v[k] !== 1'b1 || o_i[k] !== CW'(e_i[k]) || o_j[k] !== CW'(e_j[k])) begin
          errors++;
          $display("FAIL hold_cell%0d piece %0d got v=%b (%0d,%0d) exp (%0d,%0d)",
                   k, hold, o_v[k], o_i[k], o_j[k], e_i[k], e_j[k]);
        end
      end
      checks++;
      if (o_pt[0] !== hold || o_nt[0] !== head || o_nt[5] !== head || o_done[4] !== 1'b1) begin
        errors++;
        $display("FAIL hold_queue got piece=%0d next=%0d/%0d done=%b exp %0d %0d 1",
                 o_pt[0], o_nt[0], o_nt[5], o_done[4], hold, head);
      end
    end
  endtask

  task automatic test_probe();
    logic [2:0] pc, head;
    int ai, aj, rot;
    for (int n = 0; n < 22; n++) begin
      if (n == 0) begin pc = PI; ai = 5; aj = 2; rot = 1; end
      else if (n == 1) begin pc = PL; ai = 0; aj = 8; rot = 0; end
      else begin
        pc = 3'($urandom_range(1, 7)); ai = $urandom_range(0, 31);
        aj = $urandom_range(0, 31); rot = $urandom_range(0, 3);
      end
      wait_idle();
      head = pq[0];
      expect_piece(pc, rot, ai, aj);
      send_req(1'b1, 3'($urandom_range(0, 7)), pc, ai, aj, rot);
      collect();
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (o_v[k] !== 1'b1 || o_idx[k] !== 2'(k) || o_i[k] !== CW'(e_i[k]) || o_j[k] !== CW'(e_j[k])) begin
          errors++;
          $display("FAIL probe_cell%0d p%0d a(%0d,%0d) r%0d got idx=%0d (%0d,%0d) exp idx=%0d (%0d,%0d)",
                   k, pc, ai, aj, rot, o_idx[k], o_i[k], o_j[k], k, e_i[k], e_j[k]);
        end
      end
      checks++;
      if (o_pt[2] !== pc || o_done[4] !== 1'b1 || o_oob[4] !== e_oob || o_nt[5] !== head) begin
        errors++;
        $display("FAIL probe_done got piece=%0d done=%b oob=%b next=%0d exp %0d 1 %b %0d",
                 o_pt[2], o_done[4], o_oob[4], o_nt[5], pc, e_oob, head);
      end
      if (n == 0) begin
        checks++;
        if (o_i[0] !== 5'd5 || o_j[0] !== 5'd4 || o_i[3] !== 5'd8 || o_j[3] !== 5'd4) begin
          errors++;
          $display("FAIL probe_i_rot1 got (%0d,%0d)..(%0d,%0d) exp (5,4)..(8,4)", o_i[0], o_j[0], o_i[3], o_j[3]);
        end
      end
      if (n == 1) begin
        checks++;
        if (o_i[0] !== 5'd0 || o_j[0] !== 5'd10 || o_oob[4] !== 1'b1) begin
          errors++;
          $display("FAIL probe_l_oob got (%0d,%0d) oob=%b exp (0,10) oob=1", o_i[0], o_j[0], o_oob[4]);
        end
      end
    end
  endtask

  task automatic test_q_rot();
    int ai, aj;
    for (int n = 0; n < 4; n++) begin
      ai = $urandom_range(0, 18); aj = $urandom_range(0, 8);
      expect_piece(PQ, 0, ai, aj);
      wait_idle();
      send_req(1'b1, NULLP, PQ, ai, aj, (n % 2 == 0) ? 3 : 0);
      collect();
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (o_i[k] !== CW'(e_i[k]) || o_j[k] !== CW'(e_j[k])) begin
          errors++;
          $display("FAIL q_rot%0d_cell%0d got (%0d,%0d) exp (%0d,%0d)",
                   (n % 2 == 0) ? 3 : 0, k, o_i[k], o_j[k], e_i[k], e_j[k]);
        end
      end
    end
  endtask

  task automatic test_req_during_emit();
    int dones = 0, valids = 0;
    logic [2:0] head;
    logic [1:0] idle_dbg;
    wait_idle();
    head = pq[0];
    idle_dbg = dbg_state;
    send_req(1'b1, NULLP, PT, 2, 2, 1);
    checks++;
    if (dbg_state === idle_dbg) begin
      errors++; $display("FAIL emit_state got %0d exp not idle %0d", dbg_state, idle_dbg);
    end
    for (int s = 0; s < 10; s++) begin
      if (s > 0) @(negedge clk);
      if (cell_valid === 1'b1) valids++;
      if (done === 1'b1) dones++;
      if (s == 1) begin mode = 1'b0; hold_piece_type = NULLP; req = 1'b1; end
      if (s == 2) req = 1'b0;
    end
    checks++;
    if (dones != 1 || valids != 4 || next_tetris !== head) begin
      errors++;
      $display("FAIL emit_req_ignored got dones=%0d valids=%0d next=%0d exp 1 4 %0d",
               dones, valids, next_tetris, head);
    end
  endtask

  task automatic test_reset_mid_emit();
    int n = 0, dones = 0;
    wait_idle();
    send_req(1'b1, NULLP, PI, 3, 3, 0);
    repeat (2) @(negedge clk);
    checks++;
    if (cell_valid !== 1'b1 || cell_idx !== 2'd2) begin
      errors++; $display("FAIL abort_setup got valid=%b idx=%0d exp 1 2", cell_valid, cell_idx);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (cell_valid !== 1'b0 || done !== 1'b0 || ready !== 1'b0) begin
      errors++;
      $display("FAIL abort_immediate got valid=%b done=%b ready=%b exp 0 0 0", cell_valid, done, ready);
    end
    @(negedge clk);
    reset = 1'b0;
    while (ready !== 1'b1 && n < 100) begin
      @(negedge clk); n++;
      if (done === 1'b1) dones++;
    end
    checks++;
    if (dones != 0 || n != first_fill) begin
      errors++;
      $display("FAIL abort_refill got dones=%0d fill=%0d exp 0 %0d", dones, n, first_fill);
    end
    checks++;
    if (next_tetris !== pq[0] || pq.size() != DEPTH) begin
      errors++; $display("FAIL abort_seed got next=%0d exp %0d", next_tetris, pq[0]);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_spawn();
    test_hold();
    test_probe();
    test_q_rot();
    test_req_during_emit();
    test_reset_mid_emit();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
